// File: rtl/p_mul_issue_if.sv
// Request, multiplier and response channels of the packed-multiplier issue sequencer.
// master = the sequencer, slave = the issue stage / multiplier / response consumer side.
interface p_mul_issue_if;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic        req_clmul;
  logic [4:0]  req_pw;
  logic [31:0] req_rs1, req_rs2;

  logic        mul_valid, mul_ready, mul_l, mul_h, mul_clmul;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1, mul_crs2, mul_result;

  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_lo, rsp_hi;

  modport master (
    input  req_valid, req_op, req_clmul, req_pw, req_rs1, req_rs2,
    output req_ready,
    output mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2,
    input  mul_ready, mul_result,
    output rsp_valid, rsp_lo, rsp_hi, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_clmul, req_pw, req_rs1, req_rs2,
    input  req_ready,
    input  mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2,
    output mul_ready, mul_result,
    input  rsp_valid, rsp_lo, rsp_hi, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/p_mul_issue.sv
// Issue sequencer for the packed multiplier: one or two valid/ready transfers per command, buffered response.
// Optional macro P_MUL_ISSUE_TIMEOUT_EN aborts a transfer stalled for TIMEOUT cycles with an error response.
module p_mul_issue #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic           clock,
  input  logic           resetn,
  p_mul_issue_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, RESP} state_t;

  if (TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
    $error("TIMEOUT does not fit in TO_W bits");
  end

  state_t state, state_nxt;
  logic   wide_q;
  logic   xfer_done;
  logic   abort;

  assign xfer_done = bus.mul_valid && bus.mul_ready;

`ifdef P_MUL_ISSUE_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Counter idles at 0 whenever no request is pending, so entry to either issue state starts clean.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                           to_cnt <= '0;
    else if (!bus.mul_valid || bus.mul_ready) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end

  assign abort = bus.mul_valid && !bus.mul_ready && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (bus.req_op == 2'b11) ? RESP : ISSUE_A;
      ISSUE_A: if (xfer_done)     state_nxt = wide_q ? ISSUE_B : RESP;
               else if (abort)    state_nxt = RESP;
      ISSUE_B: if (xfer_done || abort) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.mul_valid <= 1'b0;
      bus.mul_l     <= 1'b0;
      bus.mul_h     <= 1'b0;
      bus.mul_clmul <= 1'b0;
      bus.mul_pw    <= '0;
      bus.mul_crs1  <= '0;
      bus.mul_crs2  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_lo    <= '0;
      bus.rsp_hi    <= '0;
      wide_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          if (bus.req_op == 2'b11) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_lo    <= '0;
            bus.rsp_hi    <= '0;
          end else begin
            bus.mul_valid <= 1'b1;
            bus.mul_l     <= (bus.req_op != 2'b01);
            bus.mul_h     <= (bus.req_op == 2'b01);
            bus.mul_clmul <= bus.req_clmul;
            bus.mul_pw    <= bus.req_pw;
            bus.mul_crs1  <= bus.req_rs1;
            bus.mul_crs2  <= bus.req_rs2;
            wide_q        <= (bus.req_op == 2'b10);
          end
        end
        ISSUE_A: if (xfer_done) begin
          bus.rsp_lo <= bus.mul_result;
          if (wide_q) begin
            // Flip to the high half with no bubble; operands stay put.
            bus.mul_l <= 1'b0;
            bus.mul_h <= 1'b1;
          end else begin
            bus.rsp_hi    <= '0;
            bus.mul_valid <= 1'b0;
            bus.rsp_valid <= 1'b1;
          end
        end else if (abort) begin
          bus.mul_valid <= 1'b0;
          bus.rsp_lo    <= '0;
          bus.rsp_hi    <= '0;
          bus.rsp_err   <= 1'b1;
          bus.rsp_valid <= 1'b1;
        end
        ISSUE_B: if (xfer_done) begin
          bus.rsp_hi    <= bus.mul_result;
          bus.mul_valid <= 1'b0;
          bus.rsp_valid <= 1'b1;
        end else if (abort) begin
          bus.mul_valid <= 1'b0;
          bus.rsp_lo    <= '0;
          bus.rsp_hi    <= '0;
          bus.rsp_err   <= 1'b1;
          bus.rsp_valid <= 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_p_mul_issue.sv
// Bench for p_mul_issue: transaction-level model (expected transfer queue + expected response) checked every cycle.
module tb_p_mul_issue;
`ifdef P_MUL_ISSUE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  p_mul_issue_if bus();

  p_mul_issue #(.TIMEOUT(TMO), .TO_W(8)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Ideal multiplier feeding the DUT: unsigned product, half picked by mul_l.
  logic [63:0] prod;
  assign prod = 64'(bus.mul_crs1) * 64'(bus.mul_crs2);
  assign bus.mul_result = bus.mul_l ? prod[31:0] : prod[63:32];

  typedef struct packed {
    logic        l;
    logic        clmul;
    logic [4:0]  pw;
    logic [31:0] a;
    logic [31:0] b;
  } xfer_t;

  xfer_t       xq[$];
  bit          busy = 0;
  logic [31:0] e_lo = '0, e_hi = '0;
  logic        e_err = 1'b0;
  int          waitc = 0;
  int          hs_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_lo = '0, last_hi = '0;
  logic        last_err = 1'b0;

  int rdy_delay = 0;   // -1 never ready, -2 random per transfer
  int rsp_hold = 0;
  bit rsp_rand = 0;

  task automatic accept();
    logic [63:0] p;
    xfer_t x;
    p       = 64'(bus.req_rs1) * 64'(bus.req_rs2);
    x.clmul = bus.req_clmul;
    x.pw    = bus.req_pw;
    x.a     = bus.req_rs1;
    x.b     = bus.req_rs2;
    e_err   = 1'b0;
    case (bus.req_op)
      2'b00: begin x.l = 1'b1; xq.push_back(x); e_lo = p[31:0];  e_hi = '0; end
      2'b01: begin x.l = 1'b0; xq.push_back(x); e_lo = p[63:32]; e_hi = '0; end
      2'b10: begin
        x.l = 1'b1; xq.push_back(x);
        x.l = 1'b0; xq.push_back(x);
        e_lo = p[31:0]; e_hi = p[63:32];
      end
      default: begin e_lo = '0; e_hi = '0; e_err = 1'b1; end
    endcase
    busy = 1;
  endtask

  // Compare process: outputs for the upcoming edge, then advance the model by that edge's events.
  always @(negedge clock) begin
    bit pend;
    if (!resetn) begin
      busy = 0;
      xq.delete();
      waitc = 0;
    end else begin
      pend = (xq.size() != 0);
      chk("req_ready", 96'(bus.req_ready), 96'(!busy));
      chk("mul_valid", 96'(bus.mul_valid), 96'(pend));
      if (pend)
        chk("mul_fields",
            96'({bus.mul_l, bus.mul_h, bus.mul_clmul, bus.mul_pw, bus.mul_crs1, bus.mul_crs2}),
            96'({xq[0].l, !xq[0].l, xq[0].clmul, xq[0].pw, xq[0].a, xq[0].b}));
      chk("rsp_valid", 96'(bus.rsp_valid), 96'(busy && !pend));
      if (busy && !pend)
        chk("rsp_data", 96'({bus.rsp_lo, bus.rsp_hi, bus.rsp_err}), 96'({e_lo, e_hi, e_err}));

      if (pend) begin
        if (bus.mul_ready) begin
          void'(xq.pop_front());
          waitc = 0;
          hs_cnt++;
        end else begin
          waitc++;
`ifdef P_MUL_ISSUE_TIMEOUT_EN
          if (waitc == TMO) begin
            xq.delete();
            e_lo = '0; e_hi = '0; e_err = 1'b1;
            waitc = 0;
          end
`endif
        end
      end else if (busy && bus.rsp_ready) begin
        busy = 0;
        last_lo = bus.rsp_lo; last_hi = bus.rsp_hi; last_err = bus.rsp_err;
        rsp_cnt++;
      end
      if (!busy && bus.req_valid && bus.req_ready) accept();
    end
  end

  // Multiplier responder: mul_ready after a programmable wait; random noise while no request is pending.
  int  r_wcnt = 0, r_cur = 0;
  bit  r_hs;
  initial begin
    bus.mul_ready = 1'b0;
    forever begin
      @(negedge clock);
      r_hs = bus.mul_valid && bus.mul_ready;
      @(posedge clock);
      #1;
      if (!bus.mul_valid) begin
        r_wcnt = 0;
        bus.mul_ready = 1'($urandom_range(0, 1));
      end else begin
        if (r_hs) r_wcnt = 0;
        if (r_wcnt == 0) r_cur = (rdy_delay < -1) ? int'($urandom_range(0, 3)) : rdy_delay;
        bus.mul_ready = (r_cur >= 0) && (r_wcnt >= r_cur);
        r_wcnt++;
      end
    end
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rsp_hold > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) rsp_hold--;
      end else begin
        bus.rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [4:0] pw);
    int n = 0;
    bit hs = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b;
    bus.req_clmul = c; bus.req_pw = pw;
    while (!hs && n < 300) begin
      @(negedge clock);
      hs = bus.req_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!hs) chk("send_bound", 96'(hs), 96'(1));
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom); bus.req_rs1 = $urandom; bus.req_rs2 = $urandom;
    bus.req_clmul = 1'($urandom); bus.req_pw = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit rdy = 0;
    while (!rdy && n < 300) begin
      @(negedge clock);
      rdy = bus.req_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!rdy) chk("idle_bound", 96'(rdy), 96'(1));
  endtask

  int h0, r0, n;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_clmul = 1'b0; bus.req_pw = '0;
    #2;
    chk("rst_outputs", 96'({bus.mul_valid, bus.rsp_valid, bus.rsp_err, bus.mul_l, bus.mul_h, bus.rsp_lo, bus.rsp_hi}), 96'(0));
    chk("rst_req_ready", 96'(bus.req_ready), 96'(1));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock); #1;

    // mul_l, slow multiplier
    rdy_delay = 3; h0 = hs_cnt;
    send(2'b00, 32'd3, 32'd5, 1'b0, 5'b00001);
    wait_idle();
    chk("mull_rsp", 96'({last_lo, last_hi, last_err}), 96'({32'h0000000F, 32'h0, 1'b0}));
    chk("mull_hs", 96'(hs_cnt - h0), 96'(1));

    // wide, immediate ready
    rdy_delay = 0; h0 = hs_cnt;
    send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'b00100);
    wait_idle();
    chk("wide_rsp", 96'({last_lo, last_hi, last_err}), 96'({32'h00000001, 32'hFFFFFFFE, 1'b0}));
    chk("wide_hs", 96'(hs_cnt - h0), 96'(2));

    // mul_h
    h0 = hs_cnt;
    send(2'b01, 32'h80000000, 32'd2, 1'b0, 5'b10000);
    wait_idle();
    chk("mulh_rsp", 96'({last_lo, last_hi, last_err}), 96'({32'h00000001, 32'h0, 1'b0}));
    chk("mulh_hs", 96'(hs_cnt - h0), 96'(1));

    // response back-pressure for 10 cycles
    rsp_hold = 10; r0 = rsp_cnt;
    send(2'b00, 32'd7, 32'd9, 1'b0, 5'b00010);
    wait_idle();
    chk("bp_rsp", 96'({last_lo, last_err}), 96'({32'd63, 1'b0}));
    chk("bp_count", 96'(rsp_cnt - r0), 96'(1));

    // reserved op
    h0 = hs_cnt;
    send(2'b11, 32'h1234, 32'h5678, 1'b0, 5'b00001);
    wait_idle();
    chk("rsvd_rsp", 96'({last_lo, last_hi, last_err}), 96'({32'h0, 32'h0, 1'b1}));
    chk("rsvd_hs", 96'(hs_cnt - h0), 96'(0));

    // reset while waiting in ISSUE_A
    rdy_delay = -1; r0 = rsp_cnt;
    send(2'b00, 32'd11, 32'd13, 1'b0, 5'b00001);
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1 chk("rst_mid", 96'({bus.mul_valid, bus.rsp_valid}), 96'(0));
    @(posedge clock); #1 resetn = 1'b1;
    rdy_delay = 0;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_after_rdy", 96'(bus.req_ready), 96'(1));
    chk("rst_no_rsp", 96'(rsp_cnt - r0), 96'(0));

`ifdef P_MUL_ISSUE_TIMEOUT_EN
    rdy_delay = -1;
    send(2'b10, 32'd5, 32'd6, 1'b0, 5'b00001);
    n = 0;
    while (bus.mul_valid && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    chk("to_cycles", 96'(n), 96'(16));
    wait_idle();
    chk("to_rsp", 96'({last_lo, last_hi, last_err}), 96'({32'h0, 32'h0, 1'b1}));
`endif

    // randomized traffic
    rdy_delay = -2; rsp_rand = 1;
    for (int i = 0; i < 150; i++) begin
      send(2'($urandom), $urandom, $urandom, 1'($urandom), 5'(1 << $urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
      #0;
    end
    rsp_rand = 0;
    wait_idle();
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/p_mul_issue.md
Name: p_mul_issue

Overview:
- Initiator-side sequencer for the packed multiplier's valid/ready request interface.
- Accepts multiply commands from the issue stage and drives the multiplier's request port.
- Holds the request stable until the multiplier returns ready, then captures the result.
- Decomposes a 64-bit "wide" command into two back-to-back multiplier transfers (low half, then high half) and returns a buffered response with back-pressure.

Parameters:
TIMEOUT, 255, cycles mul_valid may stay high without mul_ready before abort (used only with the macro)
TO_W, 8, width of the timeout counter; TIMEOUT must be < 2**TO_W

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_op  in  2  00 mul_l, 01 mul_h, 10 wide (64-bit), 11 reserved
req_clmul  in  1  carry-less select, forwarded unchanged
req_pw  in  5  one-hot pack width, forwarded unchanged
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
mul_valid  out  1  request to multiplier
mul_ready  in  1  multiplier done; result valid this cycle
mul_l  out  1  low-half select
mul_h  out  1  high-half select; always !mul_l while mul_valid
mul_clmul  out  1  latched req_clmul
mul_pw  out  5  latched req_pw
mul_crs1  out  32  latched req_rs1
mul_crs2  out  32  latched req_rs2
mul_result  in  32  multiplier result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_lo  out  32  low result word
rsp_hi  out  32  high result word
rsp_err  out  1  error response

Behaviour:
- Reset: all registered outputs go to 0 asynchronously; state goes to IDLE. Reset mid-operation aborts it: mul_valid drops immediately and no response is produced.
- States: IDLE, ISSUE_A, ISSUE_B, RESP.
- req_ready = (state==IDLE). This is the only combinational output.
- IDLE, accepting op 00/01/10:
  - Latch operands, clmul and pw.
  - Next cycle: state ISSUE_A, mul_valid=1.
  - mul_l=1 for ops 00 and 10; mul_l=0 for op 01.
- IDLE, accepting op 11:
  - Next state RESP, with rsp_valid=1, rsp_err=1, rsp_lo=rsp_hi=0.
  - mul_valid is never raised.
- Handshake rule: while mul_valid=1, every mul_* output is held constant until a cycle with mul_ready=1. That cycle completes the transfer and mul_result is sampled at its closing edge.
- ISSUE_A with mul_ready=1:
  - Ops 00/01: rsp_lo<=mul_result, rsp_hi<=0, mul_valid<=0, state RESP.
  - Op 10: rsp_lo<=mul_result, mul_l<=0, mul_h<=1, state ISSUE_B. mul_valid stays high with no gap; operands are unchanged.
- ISSUE_B with mul_ready=1: rsp_hi<=mul_result, mul_valid<=0, state RESP.
- RESP:
  - rsp_valid=1 and rsp_lo/rsp_hi/rsp_err are held stable until rsp_ready.
  - On handshake: rsp_valid<=0, rsp_err<=0, state IDLE.
- No command is accepted until the response drains. Minimum occupancy: 3 cycles single, 4 cycles wide (mul_ready immediate, rsp_ready high).
- mul_ready while mul_valid=0 is ignored.

Optional Feature:
- Macro P_MUL_ISSUE_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on entry to ISSUE_A/ISSUE_B and on every mul_ready.
  - It increments each cycle mul_valid=1 && mul_ready=0.
  - When it reaches TIMEOUT: mul_valid<=0, rsp_lo=rsp_hi=0, rsp_err=1, state RESP. A late mul_ready after abort is ignored.
- When undefined: no counter, the block waits indefinitely, and rsp_err is set only for op 11.

Test Plan:
- Op 00, rs1=3, rs2=5, pw=00001, mul_ready after 4 cycles -> mul_crs1/crs2/mul_l stable all 4 cycles; rsp_lo=0000000F, rsp_hi=0, rsp_err=0; one handshake only.
- Op 10, rs1=rs2=FFFFFFFF, mul_ready immediate -> two consecutive handshakes, first mul_l=1 then mul_h=1, mul_valid never low between; rsp_lo=00000001, rsp_hi=FFFFFFFE.
- Op 01, rs1=80000000, rs2=2 -> single transfer with mul_h=1; rsp_lo=00000001, rsp_hi=0.
- Response back-pressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0, mul_valid=0 throughout; accepted on cycle 11, req_ready=1 next cycle.
- Op 11 -> mul_valid stays 0; rsp_valid next cycle with rsp_err=1, rsp_lo=rsp_hi=0.
- resetn low while ISSUE_A waiting -> mul_valid and rsp_valid 0 immediately; after release req_ready=1 with no spurious response.
- With P_MUL_ISSUE_TIMEOUT_EN and TIMEOUT=16, mul_ready never asserted -> mul_valid drops after 16 cycles; rsp_err=1.
